// File: rtl/gf_exp_ctrl.sv
// gf_exp_ctrl: computes result = base^exp in GF(2^M) by left-to-right square-and-multiply.
// The field multiplier lives outside this block; we drive its operands and capture its product.
//
// Ports:
//   clk_i      rising-edge clock
//   rst_i      synchronous, active-high reset
//   start_i    1-cycle request, accepted only while idle
//   base_i     base element, sampled on accepted start
//   exp_i      exponent, sampled on accepted start
//   busy_o     high from the cycle after acceptance until (and including) the done cycle
//   done_o     1-cycle pulse; result_o valid from this cycle
//   result_o   final accumulator, held until the next accepted start completes
//   mul_req_o  multiplier operands valid, product requested
//   mul_a_o    multiplier operand A
//   mul_b_o    multiplier operand B
//   mul_g_i    multiplier product, valid when mul_ack_i=1
//   mul_ack_i  product valid this cycle (ignored while mul_req_o=0)
module gf_exp_ctrl #(
   parameter int unsigned M  = 3,
   parameter int unsigned EW = 4
) (
   input  logic          clk_i,
   input  logic          rst_i,
   input  logic          start_i,
   input  logic [M-1:0]  base_i,
   input  logic [EW-1:0] exp_i,
   output logic          busy_o,
   output logic          done_o,
   output logic [M-1:0]  result_o,
   output logic          mul_req_o,
   output logic [M-1:0]  mul_a_o,
   output logic [M-1:0]  mul_b_o,
   input  logic [M-1:0]  mul_g_i,
   input  logic          mul_ack_i
);

   localparam int unsigned IW = (EW > 1) ? $clog2(EW) : 1;

   typedef enum logic [1:0] {StIdle, StSqr, StMul, StDone} state_e;

   state_e          state_q;
   logic [M-1:0]    acc_q;
   logic [M-1:0]    base_q;
   logic [EW-1:0]   exp_q;
   logic [IW-1:0]   idx_q;
   logic            busy_q;
   logic            done_q;
   logic [M-1:0]    result_q;
   logic            mul_req_q;
   logic [M-1:0]    mul_a_q;
   logic [M-1:0]    mul_b_q;

   // Operands are registered one step ahead: whenever the next state is SQR or MUL,
   // mul_a/mul_b are loaded with the value the accumulator will hold in that state.
   // The final product goes straight into result_q so result is valid in the done cycle.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q   <= StIdle;
         acc_q     <= '0;
         base_q    <= '0;
         exp_q     <= '0;
         idx_q     <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         result_q  <= '0;
         mul_req_q <= 1'b0;
         mul_a_q   <= '0;
         mul_b_q   <= '0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (start_i) begin
                  base_q    <= base_i;
                  exp_q     <= exp_i;
                  acc_q     <= M'(1);
                  idx_q     <= IW'(EW - 1);
                  state_q   <= StSqr;
                  busy_q    <= 1'b1;
                  mul_req_q <= 1'b1;
                  mul_a_q   <= M'(1);
                  mul_b_q   <= M'(1);
               end
            end
            StSqr: begin
               if (mul_ack_i) begin
                  acc_q <= mul_g_i;
                  if (exp_q[idx_q]) begin
                     state_q <= StMul;
                     mul_a_q <= mul_g_i;
                     mul_b_q <= base_q;
                  end else if (idx_q == '0) begin
                     state_q   <= StDone;
                     done_q    <= 1'b1;
                     result_q  <= mul_g_i;
                     mul_req_q <= 1'b0;
                     mul_a_q   <= '0;
                     mul_b_q   <= '0;
                  end else begin
                     idx_q   <= idx_q - 1'b1;
                     mul_a_q <= mul_g_i;
                     mul_b_q <= mul_g_i;
                  end
               end
            end
            StMul: begin
               if (mul_ack_i) begin
                  acc_q <= mul_g_i;
                  if (idx_q == '0) begin
                     state_q   <= StDone;
                     done_q    <= 1'b1;
                     result_q  <= mul_g_i;
                     mul_req_q <= 1'b0;
                     mul_a_q   <= '0;
                     mul_b_q   <= '0;
                  end else begin
                     idx_q   <= idx_q - 1'b1;
                     state_q <= StSqr;
                     mul_a_q <= mul_g_i;
                     mul_b_q <= mul_g_i;
                  end
               end
            end
            StDone: begin
               // start is ignored here; it is only accepted once back in IDLE
               done_q  <= 1'b0;
               busy_q  <= 1'b0;
               state_q <= StIdle;
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign busy_o    = busy_q;
   assign done_o    = done_q;
   assign result_o  = result_q;
   assign mul_req_o = mul_req_q;
   assign mul_a_o   = mul_a_q;
   assign mul_b_o   = mul_b_q;

endmodule

// File: tb/tb_gf_exp_ctrl.sv
// tb_gf_exp_ctrl: self-checking bench for gf_exp_ctrl with a behavioural GF(8) multiplier
// (x^3 = x^2 + 1) and a configurable ack delay.
`timescale 1ns/1ps
module tb_gf_exp_ctrl;

   localparam int M  = 3;
   localparam int EW = 4;

   logic          clk = 1'b0;
   logic          rst;
   logic          start_s;
   logic [M-1:0]  base_s;
   logic [EW-1:0] exp_s;
   logic          busy;
   logic          done;
   logic [M-1:0]  result;
   logic          mul_req;
   logic [M-1:0]  mul_a;
   logic [M-1:0]  mul_b;
   logic [M-1:0]  mul_g;
   logic          mul_ack;

   int checks   = 0;
   int failures = 0;

   int delay    = 0;
   int wait_cnt = 0;
   int op_total = 0;
   int stab_err = 0;
   logic          waiting_q = 1'b0;
   logic [M-1:0]  pa = '0;
   logic [M-1:0]  pb = '0;

   always #5 clk = ~clk;

   gf_exp_ctrl #(.M(M), .EW(EW)) dut (
      .clk_i     (clk),
      .rst_i     (rst),
      .start_i   (start_s),
      .base_i    (base_s),
      .exp_i     (exp_s),
      .busy_o    (busy),
      .done_o    (done),
      .result_o  (result),
      .mul_req_o (mul_req),
      .mul_a_o   (mul_a),
      .mul_b_o   (mul_b),
      .mul_g_i   (mul_g),
      .mul_ack_i (mul_ack)
   );

   // Carry-less product reduced modulo x^3 + x^2 + 1.
   function automatic logic [2:0] gf_mul(input logic [2:0] a, input logic [2:0] b);
      logic [4:0] p;
      p = '0;
      for (int k = 0; k < 3; k++) if (b[k]) p = p ^ (5'(a) << k);
      for (int k = 4; k >= 3; k--) if (p[k]) p = p ^ (5'b01101 << (k - 3));
      return p[2:0];
   endfunction

   // Reference: base^exp by plain repeated multiplication.
   function automatic logic [2:0] gf_pow(input logic [2:0] b, input int e);
      logic [2:0] r;
      r = 3'b001;
      for (int k = 0; k < e; k++) r = gf_mul(r, b);
      return r;
   endfunction

   function automatic int popcnt(input logic [3:0] e);
      int n;
      n = 0;
      for (int k = 0; k < 4; k++) n += int'(e[k]);
      return n;
   endfunction

   always_comb begin
      mul_g   = gf_mul(mul_a, mul_b);
      mul_ack = mul_req && (wait_cnt >= delay);
   end

   // Ack-delay counter, op counter and operand-stability monitor.
   always @(posedge clk) begin
      if (mul_req && !mul_ack) wait_cnt <= wait_cnt + 1;
      else wait_cnt <= 0;
      if (mul_req && mul_ack) op_total <= op_total + 1;
      if (waiting_q && (!mul_req || mul_a != pa || mul_b != pb)) stab_err <= stab_err + 1;
      waiting_q <= mul_req && !mul_ack;
      pa <= mul_a;
      pb <= mul_b;
   end

   // Issue one start and wait (bounded) for done; returns at the negedge of the done cycle.
   task automatic run_op(input logic [2:0] b, input logic [3:0] e, output int lat,
                         output logic [2:0] res, output int ops, output bit to);
      int ops0;
      @(negedge clk);
      base_s = b; exp_s = e; start_s = 1'b1;
      ops0 = op_total;
      @(negedge clk);
      start_s = 1'b0;
      lat = 1;
      while (!done && lat < 200) begin
         @(negedge clk);
         lat++;
      end
      to  = !done;
      res = result;
      ops = op_total - ops0;
   endtask

   task automatic test_reset();
      rst = 1'b1; start_s = 1'b0; base_s = '0; exp_s = '0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      checks++;
      if ({busy, done, result, mul_req, mul_a, mul_b} !== '0) begin
         failures++;
         $display("FAIL reset_outputs got busy=%b done=%b result=%b req=%b a=%b b=%b want all 0",
                  busy, done, result, mul_req, mul_a, mul_b);
      end
      @(negedge clk);
      checks++;
      if (busy !== 1'b0 || mul_req !== 1'b0) begin
         failures++;
         $display("FAIL reset_idle got busy=%b req=%b want 0 0", busy, mul_req);
      end
   endtask

   task automatic test_directed();
      logic [2:0] tb_b [4];
      logic [3:0] tb_e [4];
      logic [2:0] tb_r [4];
      int         tb_l [4];
      int lat, ops;
      logic [2:0] res;
      bit to;
      tb_b = '{3'b010, 3'b010, 3'b000, 3'b011};
      tb_e = '{4'b0011, 4'b0111, 4'b0000, 4'b1111};
      tb_r = '{3'b101, 3'b001, 3'b001, 3'b011};
      tb_l = '{7, 8, 5, 9};
      delay = 0;
      for (int n = 0; n < 4; n++) begin
         run_op(tb_b[n], tb_e[n], lat, res, ops, to);
         checks++;
         if (to || res !== tb_r[n] || res !== gf_pow(tb_b[n], int'(tb_e[n]))) begin
            failures++;
            $display("FAIL directed%0d_result got %b (timeout=%0d) want %b", n, res, to, tb_r[n]);
         end
         checks++;
         if (lat != tb_l[n] || ops != EW + popcnt(tb_e[n])) begin
            failures++;
            $display("FAIL directed%0d_timing got lat=%0d ops=%0d want lat=%0d ops=%0d", n, lat,
                     ops, tb_l[n], EW + popcnt(tb_e[n]));
         end
         @(negedge clk);
         checks++;
         if (done !== 1'b0 || busy !== 1'b0 || result !== tb_r[n]) begin
            failures++;
            $display("FAIL directed%0d_after got done=%b busy=%b result=%b want 0 0 %b", n, done,
                     busy, result, tb_r[n]);
         end
      end
   endtask

   task automatic test_stall();
      int lat, ops, s0;
      logic [2:0] res;
      bit to;
      delay = 3;
      s0 = stab_err;
      run_op(3'b010, 4'b0011, lat, res, ops, to);
      checks++;
      if (to || res !== 3'b101 || lat != 25) begin
         failures++;
         $display("FAIL stall_case got result=%b lat=%0d want 101 25", res, lat);
      end
      checks++;
      if (stab_err != s0) begin
         failures++;
         $display("FAIL stall_stable got %0d operand changes while waiting want 0", stab_err - s0);
      end
      delay = 0;
   endtask

   task automatic test_random();
      int lat, ops, s0;
      logic [2:0] b, res;
      logic [3:0] e;
      bit to;
      s0 = stab_err;
      for (int n = 0; n < 20; n++) begin
         b = 3'($urandom_range(0, 7));
         e = 4'($urandom_range(0, 15));
         delay = $urandom_range(0, 2);
         run_op(b, e, lat, res, ops, to);
         checks++;
         if (to || res !== gf_pow(b, int'(e)) || ops != EW + popcnt(e)
             || lat != (EW + popcnt(e)) * (delay + 1) + 1) begin
            failures++;
            $display("FAIL random%0d b=%b e=%b d=%0d got res=%b ops=%0d lat=%0d want %b %0d %0d",
                     n, b, e, delay, res, ops, lat, gf_pow(b, int'(e)), EW + popcnt(e),
                     (EW + popcnt(e)) * (delay + 1) + 1);
         end
      end
      checks++;
      if (stab_err != s0) begin
         failures++;
         $display("FAIL random_stable got %0d operand changes want 0", stab_err - s0);
      end
      delay = 0;
   endtask

   task automatic test_busy_start();
      int lat;
      delay = 0;
      @(negedge clk);
      base_s = 3'b010; exp_s = 4'b0011; start_s = 1'b1;
      @(negedge clk);
      start_s = 1'b0;
      lat = 1;
      while (!done && lat < 200) begin
         if (lat == 2 || lat == 4) begin
            base_s = 3'b011; exp_s = 4'b1111; start_s = 1'b1;
         end
         @(negedge clk);
         start_s = 1'b0;
         lat++;
      end
      checks++;
      if (!done || result !== 3'b101 || lat != 7) begin
         failures++;
         $display("FAIL busy_start got done=%b result=%b lat=%0d want 1 101 7", done, result, lat);
      end
      @(negedge clk);
   endtask

   task automatic test_back_to_back();
      int lat, ops;
      logic [2:0] res;
      bit to;
      delay = 0;
      run_op(3'b010, 4'b0111, lat, res, ops, to);
      // start raised during the done cycle must be ignored
      base_s = 3'b011; exp_s = 4'b0001; start_s = 1'b1;
      @(negedge clk);
      start_s = 1'b0;
      checks++;
      if (busy !== 1'b0 || mul_req !== 1'b0 || result !== 3'b001) begin
         failures++;
         $display("FAIL start_in_done got busy=%b req=%b result=%b want 0 0 001", busy, mul_req,
                  result);
      end
      run_op(3'b011, 4'b0001, lat, res, ops, to);
      checks++;
      if (to || res !== 3'b011 || lat != 6) begin
         failures++;
         $display("FAIL after_done_start got result=%b lat=%0d want 011 6", res, lat);
      end
   endtask

   task automatic test_rst_mid();
      int dones, lat, ops;
      logic [2:0] res;
      bit to;
      delay = 0;
      @(negedge clk);
      base_s = 3'b011; exp_s = 4'b1111; start_s = 1'b1;
      @(negedge clk);
      start_s = 1'b0;
      @(negedge clk);
      // second op cycle of exp=1111 is the MUL step (operand B = base)
      checks++;
      if (mul_req !== 1'b1 || mul_b !== 3'b011) begin
         failures++;
         $display("FAIL rst_mid_inmul got req=%b b=%b want 1 011", mul_req, mul_b);
      end
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      checks++;
      if (busy !== 1'b0 || mul_req !== 1'b0 || done !== 1'b0) begin
         failures++;
         $display("FAIL rst_mid_state got busy=%b req=%b done=%b want 0 0 0", busy, mul_req, done);
      end
      dones = 0;
      for (int k = 0; k < 12; k++) begin
         @(negedge clk);
         if (done) dones++;
      end
      checks++;
      if (dones != 0) begin
         failures++;
         $display("FAIL rst_mid_nodone got %0d done pulses want 0", dones);
      end
      run_op(3'b011, 4'b1111, lat, res, ops, to);
      checks++;
      if (to || res !== 3'b011 || lat != 9) begin
         failures++;
         $display("FAIL rst_mid_restart got result=%b lat=%0d want 011 9", res, lat);
      end
   endtask

   initial begin
      test_reset();
      test_directed();
      test_stall();
      test_busy_start();
      test_back_to_back();
      test_random();
      test_rst_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
